// File: rtl/traffic_light_ctrl.sv
// Moore traffic-light sequencer (RED -> GREEN -> YELLOW -> RED, with an optional
// WALK phase after RED) advanced by single-cycle ticks from an upstream timer.
module traffic_light_ctrl #(
  parameter int CNT_W           = 4,
  parameter int RED_TICKS       = 6,
  parameter int GREEN_TICKS     = 8,
  parameter int MIN_GREEN_TICKS = 3,
  parameter int YELLOW_TICKS    = 2,
  parameter int WALK_TICKS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       walk,
  output logic       ped_ack,
  output logic [1:0] dbg_state_o,
  output logic       dbg_ped_pending_o
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_WALK   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RED_LAST       = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST      = CNT_W'(WALK_TICKS - 1);

  state_e           state_q, state_d, next_st;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ack_q;
  logic             red_q, yellow_q, green_q, walk_q;
  logic             req_any, terminal, enter_walk;

  always_comb begin
    req_any  = pend_q | ped_req;
    terminal = 1'b0;
    next_st  = state_q;
    case (state_q)
      S_RED: begin
        terminal = (cnt_q == RED_LAST);
        next_st  = req_any ? S_WALK : S_GREEN;
      end
      S_GREEN: begin
        // A pending request may cut green short once the minimum has elapsed.
        terminal = (cnt_q == GREEN_LAST) || (req_any && (cnt_q >= MIN_GREEN_LAST));
        next_st  = S_YELLOW;
      end
      S_YELLOW: begin
        terminal = (cnt_q == YELLOW_LAST);
        next_st  = S_RED;
      end
      S_WALK: begin
        terminal = (cnt_q == WALK_LAST);
        next_st  = S_GREEN;
      end
      default: begin
        terminal = 1'b1;
        next_st  = S_RED;
      end
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (terminal) begin
        state_d = next_st;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    enter_walk = tick && terminal && (state_q == S_RED) && req_any;

    // Entering WALK serves the request, so its clear beats a same-cycle set.
    pend_d = pend_q;
    if (enter_walk) begin
      pend_d = 1'b0;
    end else if (ped_req && (state_q != S_WALK)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RED;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      red_q    <= 1'b1;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
      walk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ack_q    <= enter_walk;
      red_q    <= (state_d == S_RED) || (state_d == S_WALK);
      yellow_q <= (state_d == S_YELLOW);
      green_q  <= (state_d == S_GREEN);
      walk_q   <= (state_d == S_WALK);
    end
  end

  assign red               = red_q;
  assign yellow            = yellow_q;
  assign green             = green_q;
  assign walk              = walk_q;
  assign ped_ack           = ack_q;
  assign dbg_state_o       = state_q;
  assign dbg_ped_pending_o = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: lamp vector {red,yellow,green,walk,ped_ack}
// checked after each step against hand-computed phase sequences.
module tb_traffic_light_ctrl;

  localparam logic [4:0] L_RED      = 5'b10000;
  localparam logic [4:0] L_YEL      = 5'b01000;
  localparam logic [4:0] L_GRN      = 5'b00100;
  localparam logic [4:0] L_WALK     = 5'b10010;
  localparam logic [4:0] L_WALK_ACK = 5'b10011;

  logic       clk = 1'b0;
  logic       reset, tick, ped_req;
  logic       red, yellow, green, walk, ped_ack;
  logic [1:0] dbg_state;
  logic       dbg_pend;
  logic [4:0] lamps;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_light_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .tick              (tick),
    .ped_req           (ped_req),
    .red               (red),
    .yellow            (yellow),
    .green             (green),
    .walk              (walk),
    .ped_ack           (ped_ack),
    .dbg_state_o       (dbg_state),
    .dbg_ped_pending_o (dbg_pend)
  );

  // clock / reset
  always #5 clk = ~clk;
  assign lamps = {red, yellow, green, walk, ped_ack};

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: one clock with given inputs, returning #1 after the edge
  task automatic cyc(input logic t, input logic r);
    tick    = t;
    ped_req = r;
    @(posedge clk);
    #1;
    tick    = 1'b0;
    ped_req = 1'b0;
  endtask

  // one tick followed by two idle cycles (tick every 3 cycles)
  task automatic send_tick(input logic r);
    cyc(1'b1, r);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] exp;
    reset   = 1'b0;
    tick    = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lamps", lamps, L_RED);
    chk("reset_pending", {4'b0, dbg_pend}, 5'd0);
    @(negedge clk);
    reset = 1'b1;

    // free run: green on tick 6, yellow 14, red 16, green 22
    for (int i = 1; i <= 22; i++) begin
      send_tick(1'b0);
      if (i < 6)       exp = L_RED;
      else if (i < 14) exp = L_GRN;
      else if (i < 16) exp = L_YEL;
      else if (i < 22) exp = L_RED;
      else             exp = L_GRN;
      chk($sformatf("free_run_t%0d", i), lamps, exp);
    end

    // asynchronous reset in the middle of GREEN
    send_tick(1'b0);
    send_tick(1'b0);
    chk("pre_reset_green", lamps, L_GRN);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_async", lamps, L_RED);
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", lamps, L_RED);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // request pulse after GREEN tick 1 shortens green to 3 ticks
    repeat (5) send_tick(1'b0);
    chk("rq_red_t5", lamps, L_RED);
    send_tick(1'b0);
    chk("rq_green_entry", lamps, L_GRN);
    send_tick(1'b0);
    cyc(1'b0, 1'b1);
    chk("rq_pending_set", {4'b0, dbg_pend}, 5'd1);
    send_tick(1'b0);
    chk("rq_green_t2", lamps, L_GRN);
    send_tick(1'b0);
    chk("rq_yellow_t3", lamps, L_YEL);
    send_tick(1'b0);
    chk("rq_yellow_t1", lamps, L_YEL);
    send_tick(1'b0);
    chk("rq_red_entry", lamps, L_RED);
    repeat (5) send_tick(1'b0);
    chk("rq_red_t5b", lamps, L_RED);
    cyc(1'b1, 1'b0);
    chk("rq_walk_entry", lamps, L_WALK_ACK);
    chk("rq_pending_clr", {4'b0, dbg_pend}, 5'd0);
    cyc(1'b0, 1'b0);
    chk("rq_ack_falls", lamps, L_WALK);

    // requests during WALK are dropped
    cyc(1'b0, 1'b1);
    repeat (3) send_tick(1'b1);
    chk("walk_t3", lamps, L_WALK);
    chk("walk_req_ignored", {4'b0, dbg_pend}, 5'd0);
    send_tick(1'b0);
    chk("walk_to_green", lamps, L_GRN);
    chk("green_pending_0", {4'b0, dbg_pend}, 5'd0);
    repeat (7) send_tick(1'b0);
    chk("nr_green_t7", lamps, L_GRN);
    send_tick(1'b0);
    chk("nr_yellow", lamps, L_YEL);
    repeat (2) send_tick(1'b0);
    chk("nr_red", lamps, L_RED);
    repeat (5) send_tick(1'b0);
    chk("nr_red_t5", lamps, L_RED);
    send_tick(1'b0);
    chk("nr_green_not_walk", lamps, L_GRN);

    // request on the terminal RED tick itself
    repeat (8) send_tick(1'b0);
    chk("tr_yellow", lamps, L_YEL);
    repeat (2) send_tick(1'b0);
    chk("tr_red", lamps, L_RED);
    repeat (5) send_tick(1'b0);
    chk("tr_pending_before", {4'b0, dbg_pend}, 5'd0);
    cyc(1'b1, 1'b1);
    chk("tr_walk_entry", lamps, L_WALK_ACK);
    chk("tr_pending_after", {4'b0, dbg_pend}, 5'd0);
    cyc(1'b0, 1'b0);
    chk("tr_ack_falls", lamps, L_WALK);
    repeat (3) send_tick(1'b0);
    chk("tr_walk_t3", lamps, L_WALK);
    send_tick(1'b0);
    chk("tr_green", lamps, L_GRN);

    // tick held high: GREEN 8 cycles, YELLOW 2, RED 6
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0);
      if (i < 8)       exp = L_GRN;
      else if (i < 10) exp = L_YEL;
      else if (i < 16) exp = L_RED;
      else             exp = L_GRN;
      chk($sformatf("tick_high_c%0d", i), lamps, exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Downstream consumer of the `timer` block's `out` tick. The timer's periodic single-cycle pulse is fed to the `tick` input. `traffic_light_ctrl` is a Moore state machine that sequences a single-approach traffic light with a pedestrian crossing phase. It counts ticks per phase, latches pedestrian requests, shortens green when a request is pending, and inserts a walk phase after red.

## Interface

Parameters:
- `CNT_W`, default 4: width of the per-phase tick counter. Every duration must be ≤ 2^CNT_W.
- `RED_TICKS`, default 6: ticks spent in RED.
- `GREEN_TICKS`, default 8: ticks spent in GREEN when no request is pending.
- `MIN_GREEN_TICKS`, default 3: minimum GREEN ticks before a pending request may cut green short. Must satisfy 1 ≤ `MIN_GREEN_TICKS` ≤ `GREEN_TICKS`.
- `YELLOW_TICKS`, default 2: ticks spent in YELLOW.
- `WALK_TICKS`, default 4: ticks spent in WALK.

Ports:
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `tick` input, 1 bit: phase-time pulse from the timer's `out`. Each cycle with `tick`=1 counts as one tick.
- `ped_req` input, 1 bit: pedestrian request, level. Sampled every cycle.
- `red` output, 1 bit: red lamp.
- `yellow` output, 1 bit: yellow lamp.
- `green` output, 1 bit: green lamp.
- `walk` output, 1 bit: pedestrian walk lamp.
- `ped_ack` output, 1 bit: one-cycle pulse acknowledging that the pending request is being served.

## Operation

- States: RED, GREEN, YELLOW, WALK. Encoding is free.
- Registers:
  - `state`
  - `tick_cnt` (CNT_W bits)
  - `ped_pending`
  - `ped_ack`
- Reset values while `reset`=0, applied asynchronously:
  - `state`=RED, `tick_cnt`=0, `ped_pending`=0
  - Outputs: `red`=1, `yellow`=0, `green`=0, `walk`=0, `ped_ack`=0
- Output decode from `state`:
  - `red`=1 in RED and WALK.
  - `yellow`=1 in YELLOW.
  - `green`=1 in GREEN.
  - `walk`=1 in WALK.
  - Exactly one of `green`/`yellow`/`red` is high at all times.
- Define `req_any` = `ped_pending` | `ped_req`.
- Tick counting:
  - On a tick that is not terminal, `tick_cnt` increments by 1.
  - On a terminal tick, the state transitions and `tick_cnt` is set to 0.
  - With `tick`=0, `tick_cnt` holds.
- Transitions (all evaluated only on cycles with `tick`=1):
  - RED: terminal when `tick_cnt`==RED_TICKS-1. Goes to WALK if `req_any`=1, else to GREEN.
  - GREEN: terminal when `tick_cnt`==GREEN_TICKS-1, or when `req_any`=1 and `tick_cnt` ≥ MIN_GREEN_TICKS-1. Goes to YELLOW.
  - YELLOW: terminal when `tick_cnt`==YELLOW_TICKS-1. Goes to RED.
  - WALK: terminal when `tick_cnt`==WALK_TICKS-1. Goes to GREEN.
- Pedestrian request latch:
  - `ped_pending` is set on any cycle with `ped_req`=1 while `state`≠WALK and the RED→WALK transition is not occurring.
  - `ped_pending` is cleared on the edge that enters WALK; the clear wins over a simultaneous set.
  - `ped_req` is ignored while in WALK, so requests made during WALK are lost.
- `ped_ack` is registered. It is 1 for exactly the first cycle in WALK and 0 otherwise.
- A duration parameter of 1 means every tick in that phase is terminal.
- `tick_cnt` never exceeds (duration-1) of the current state, so it never wraps.

## Timing

- Latency from a terminal tick to the new lamp outputs: 1 clock. The tick is sampled at edge N, and lamps change just after edge N.
- `ped_ack` rises together with `walk` and falls one clock later.
- Phase length equals its duration in ticks: `tick` pulses counted from entry, inclusive of the terminal tick. Wall time depends on tick spacing.
- `tick` held high continuously makes each clock cycle one tick, so a phase lasts exactly its duration in cycles.
- Reset asserted mid-phase: outputs go to reset values immediately, without waiting for `clk`. After `reset` deasserts, the first tick counts as RED tick 1.
- `tick` and `ped_req` are assumed synchronous to `clk`. No internal synchronisers.

## Test plan

All scenarios use default parameters with a tick every 3 cycles unless stated otherwise.

- Reset: drive `reset`=0 while in GREEN → `red`=1 and `green`/`yellow`/`walk`/`ped_ack`=0 before the next `clk` edge; they stay so until release.
- Free run, `ped_req`=0: `green` rises on the 6th tick after release; `yellow` on the 14th; `red` on the 16th; `green` again on the 22nd. `walk` and `ped_ack` never go high.
- Request during GREEN, 1-cycle `ped_req` pulse after GREEN tick 1:
  - `yellow` on GREEN tick 3.
  - After 2 YELLOW and 6 RED ticks, `walk`=1 with `red`=1 and a 1-cycle `ped_ack`.
  - `green` after 4 WALK ticks; `ped_pending` is then 0.
- Request raised only during WALK: the next RED ends in GREEN, not WALK, and `ped_ack` does not pulse.
- `ped_req`=1 in the same cycle as the terminal RED tick, with `ped_pending`=0 beforehand → next state WALK, `ped_ack` pulses, and `ped_pending`=0 after entry.
- `tick` tied high: RED lasts 6 cycles, GREEN 8, YELLOW 2, and lamps change 1 cycle after each terminal edge.
